// File: rtl/clm_rand_feed.sv
// clm_rand_feed: randomness producer for the CLM Sub-bytes stage.
// Expands a 32-bit seed with a Galois LFSR (poly 0x80200003) into N_R words of R_W bits,
// buffers them, and hands one fresh vector to the consumer per round request.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   active       global enable; low freezes everything except seed_load handling
//   seed_load    load seed into the LFSR and restart filling
//   seed         32-bit LFSR seed (zero is replaced by 1)
//   req_i        request for a fresh vector
//   load_r       one-cycle strobe; consumer captures random_vect while high
//   random_vect  packed vector, element 0 in the MSB slice
//   ready_o      a full vector is buffered
//   starve_o     sticky: a request arrived while no vector was ready
//   overrun_cnt  saturating count of requests coalesced into an already-pending one
module clm_rand_feed #(
  parameter int unsigned R_W = 8,
  parameter int unsigned N_R = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               active,
  input  logic               seed_load,
  input  logic [31:0]        seed,
  input  logic               req_i,
  output logic               load_r,
  output logic [N_R*R_W-1:0] random_vect,
  output logic               ready_o,
  output logic               starve_o,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned IW   = $clog2(N_R);
  localparam logic [31:0] Poly = 32'h8020_0003;

  localparam logic [1:0] StSeedWait = 2'd0;
  localparam logic [1:0] StFill     = 2'd1;
  localparam logic [1:0] StReady    = 2'd2;

  logic [1:0]         r_state, w_state_d;
  logic [31:0]        r_lfsr, w_lfsr_d;
  logic [IW-1:0]      r_idx, w_idx_d;
  logic               r_pend, w_pend_d;
  logic [N_R*R_W-1:0] r_buf, w_buf_d;
  logic [N_R*R_W-1:0] r_vect, w_vect_d;
  logic               r_load, w_load_d;
  logic               r_starve, w_starve_d;
  logic [7:0]         r_ovr, w_ovr_d;

  logic [31:0]        w_lfsr_step;
  logic               w_issue;
  logic               w_req;

  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? Poly : 32'h0);
  assign w_req       = active && req_i;
  // seed_load preempts an issue in the same cycle; the request then stays pending.
  assign w_issue     = (r_state == StReady) && active && (req_i || r_pend) && !seed_load;

  always_comb begin
    w_state_d  = r_state;
    w_lfsr_d   = r_lfsr;
    w_idx_d    = r_idx;
    w_pend_d   = r_pend;
    w_buf_d    = r_buf;
    w_vect_d   = r_vect;
    w_load_d   = 1'b0;
    w_starve_d = r_starve;
    w_ovr_d    = r_ovr;

    if (seed_load) begin
      w_lfsr_d  = (seed == 32'h0) ? 32'h1 : seed;
      w_idx_d   = '0;
      w_buf_d   = '0;
      w_state_d = StFill;
    end else if (active) begin
      case (r_state)
        StFill: begin
          w_lfsr_d = w_lfsr_step;
          for (int unsigned k = 0; k < N_R; k++) begin
            if (r_idx == IW'(k)) begin
              w_buf_d[(N_R-1-k)*R_W +: R_W] = w_lfsr_step[R_W-1:0];
            end
          end
          if (r_idx == IW'(N_R-1)) begin
            w_idx_d   = '0;
            w_state_d = StReady;
          end else begin
            w_idx_d = r_idx + 1'b1;
          end
        end
        StReady: begin
          if (w_issue) begin
            w_vect_d  = r_buf;
            w_load_d  = 1'b1;
            w_state_d = StFill;
          end
        end
        default: ;
      endcase
    end

    // Requests not consumed by an issue are remembered for the next ready vector.
    if (w_issue) begin
      w_pend_d = 1'b0;
    end else if (w_req) begin
      w_pend_d = 1'b1;
      if (r_pend && (r_ovr != 8'hFF)) begin
        w_ovr_d = r_ovr + 8'd1;
      end
    end
    if (w_req && (r_state != StReady)) begin
      w_starve_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StSeedWait;
      r_lfsr   <= '0;
      r_idx    <= '0;
      r_pend   <= 1'b0;
      r_buf    <= '0;
      r_vect   <= '0;
      r_load   <= 1'b0;
      r_starve <= 1'b0;
      r_ovr    <= '0;
    end else begin
      r_state  <= w_state_d;
      r_lfsr   <= w_lfsr_d;
      r_idx    <= w_idx_d;
      r_pend   <= w_pend_d;
      r_buf    <= w_buf_d;
      r_vect   <= w_vect_d;
      r_load   <= w_load_d;
      r_starve <= w_starve_d;
      r_ovr    <= w_ovr_d;
    end
  end

  assign load_r      = r_load;
  assign random_vect = r_vect;
  assign ready_o     = (r_state == StReady);
  assign starve_o    = r_starve;
  assign overrun_cnt = r_ovr;

endmodule

// File: tb/tb_clm_rand_feed.sv
// Self-checking bench for clm_rand_feed: a word-count reference model predicts every issued
// vector (pushed with its expected strobe cycle); a negedge monitor pops on load_r and also
// compares the status outputs every cycle.
module tb_clm_rand_feed;

  localparam logic [31:0] Poly = 32'h8020_0003;
  localparam logic [55:0] VecSeed1 = 56'h03020103020103;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        active = 1'b0;
  logic        seed_load = 1'b0;
  logic [31:0] seed = '0;
  logic        req = 1'b0;
  logic        load_r;
  logic [55:0] random_vect;
  logic        ready_o;
  logic        starve_o;
  logic [7:0]  overrun_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  clm_rand_feed #(.R_W(8), .N_R(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .active      (active),
    .seed_load   (seed_load),
    .seed        (seed),
    .req_i       (req),
    .load_r      (load_r),
    .random_vect (random_vect),
    .ready_o     (ready_o),
    .starve_o    (starve_o),
    .overrun_cnt (overrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    logic [55:0] v;
  } exp_t;
  exp_t q[$];

  // Reference model: words in buffer counted 0..7; "ready" means seeded and 7 words held.
  logic [31:0] m_lfsr = '0;
  logic [7:0]  m_buf[7];
  int          m_filled = 0;
  bit          m_seeded = 0;
  bit          m_pend = 0;
  bit          m_starve = 0;
  int          m_ovr = 0;
  logic [55:0] m_vect = '0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ ((x % 2 == 1) ? Poly : 32'h0);
  endfunction

  always @(posedge clk) begin
    bit ready, issue;
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      m_lfsr = '0; m_filled = 0; m_seeded = 0; m_pend = 0; m_starve = 0; m_ovr = 0;
      m_vect = '0;
      for (int k = 0; k < 7; k++) m_buf[k] = 8'h0;
    end else begin
      ready = m_seeded && (m_filled == 7);
      issue = ready && active && (req || m_pend) && !seed_load;
      if (issue) begin
        for (int k = 0; k < 7; k++) m_vect[(6-k)*8 +: 8] = m_buf[k];
        e.at = cyc;
        e.v  = m_vect;
        q.push_back(e);
        m_filled = 0;
      end
      if (seed_load) begin
        m_lfsr = (seed == 0) ? 32'h1 : seed;
        m_filled = 0;
        m_seeded = 1;
        for (int k = 0; k < 7; k++) m_buf[k] = 8'h0;
      end else if (active && m_seeded && !ready) begin
        m_lfsr = lfsr_next(m_lfsr);
        m_buf[m_filled] = m_lfsr[7:0];
        m_filled++;
      end
      if (issue) m_pend = 0;
      else if (active && req) begin
        if (m_pend && m_ovr < 255) m_ovr++;
        m_pend = 1;
      end
      if (active && req && !ready) m_starve = 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    chk("ready_o", 64'(ready_o), 64'(m_seeded && m_filled == 7));
    chk("starve_o", 64'(starve_o), 64'(m_starve));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
    chk("random_vect_hold", 64'(random_vect), 64'(m_vect));
    if (load_r) begin
      if (q.size() == 0) begin
        chk("unexpected_load_r", 64'(load_r), 64'd0);
      end else begin
        e = q.pop_front();
        chk("load_r_cycle", 64'(cyc), 64'(e.at));
        chk("issued_vect", 64'(random_vect), 64'(e.v));
      end
    end else if (q.size() != 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      chk("missing_load_r", 64'(load_r), 64'd1);
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; seed_load = 1'b0; req = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed = s; seed_load = 1'b1;
    step();
    seed_load = 1'b0;
  endtask

  initial begin
    active = 1'b1;
    do_reset();
    chk("reset_load_r", 64'(load_r), 64'd0);
    chk("reset_vect", 64'(random_vect), 64'd0);

    // seed=1: known vector, ready 7 cycles after load
    load_seed(32'h1);
    step(6);
    chk("ready_before_7", 64'(ready_o), 64'd0);
    step();
    chk("ready_at_7", 64'(ready_o), 64'd1);
    req = 1'b1; step(); req = 1'b0;
    chk("load_r_after_req", 64'(load_r), 64'd1);
    step();
    chk("vect_seed1", 64'(random_vect), 64'(VecSeed1));

    // seed=0 behaves like seed=1
    step(8);
    load_seed(32'h0);
    step(7);
    req = 1'b1; step(); req = 1'b0;
    chk("vect_seed0", 64'(random_vect), 64'(VecSeed1));

    // continuous requests
    load_seed($urandom);
    req = 1'b1; step(50); req = 1'b0; step(10);

    // three requests in one fill
    do_reset();
    load_seed(32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      req = 1'b1; step(); req = 1'b0; step();
    end
    chk("starve_in_fill", 64'(starve_o), 64'd1);
    chk("overrun_3req", 64'(overrun_cnt), 64'd2);
    step(5);

    // active dropped mid-fill
    step(5);
    load_seed(32'h1);
    step(2);
    active = 1'b0; step(5); active = 1'b1;
    step(4);
    chk("ready_delayed_not_yet", 64'(ready_o), 64'd0);
    step();
    chk("ready_delayed", 64'(ready_o), 64'd1);
    req = 1'b1; step(); req = 1'b0;
    chk("vect_after_pause", 64'(random_vect), 64'(VecSeed1));

    // reset on the issue edge
    step(7);
    req = 1'b1; rst = 1'b1; step(); req = 1'b0; rst = 1'b0;
    chk("rst_issue_load_r", 64'(load_r), 64'd0);
    chk("rst_issue_vect", 64'(random_vect), 64'd0);

    // seed_load coincident with a request in READY
    load_seed(32'h1234_5678);
    step(7);
    seed = 32'h0BAD_F00D; seed_load = 1'b1; req = 1'b1; step();
    seed_load = 1'b0; req = 1'b0;
    chk("no_load_on_seed", 64'(load_r), 64'd0);
    step(10);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      seed_load = ($urandom_range(0, 39) == 0);
      seed      = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      active    = ($urandom_range(0, 9) != 0);
      req       = ($urandom_range(0, 3) == 0);
      step();
    end
    rst = 1'b0; seed_load = 1'b0; req = 1'b0; active = 1'b1;
    step(12);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
